// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pin side and the debouncer: raw levels in,
// clean levels and single-cycle event pulses out.
interface btn_debounce_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_i;
    logic [N_BTN-1:0] btn_o;
    logic [N_BTN-1:0] press_o;
    logic [N_BTN-1:0] release_o;
    logic [N_BTN-1:0] long_o;

    modport master (
        output btn_i,
        input  btn_o,
        input  press_o,
        input  release_o,
        input  long_o
    );

    modport slave (
        input  btn_i,
        output btn_o,
        output press_o,
        output release_o,
        output long_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-flop synchronizer, debouncer and press/release edge detector.
// Optional long-press pulse is built only when BTN_LONG_PRESS_EN is defined.
module btn_debounce #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic           clk,
    input  logic           arstn,
    btn_debounce_if.slave  bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHECK_HI  = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHECK_LO  = 2'd3
    } deb_state_t;

    logic [N_BTN-1:0] w_btn;
    logic [N_BTN-1:0] w_press;
    logic [N_BTN-1:0] w_release;
    logic [N_BTN-1:0] w_long;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic          r_meta;
        logic          r_sync;
        logic [CW-1:0] r_cnt;
        logic          r_btn;
        logic          r_press;
        logic          r_release;
        deb_state_t    r_state;

        // Synchronizer plus debounce FSM; a bounce back to the old level drops all accumulated count.
        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                r_meta    <= 1'b0;
                r_sync    <= 1'b0;
                r_cnt     <= {CW{1'b0}};
                r_btn     <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_state   <= ST_STABLE_LO;
            end else begin
                r_meta    <= bus.btn_i[g];
                r_sync    <= r_meta;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    ST_STABLE_LO: begin
                        if (r_sync) begin
                            r_cnt   <= CW'(1);
                            r_state <= ST_CHECK_HI;
                        end else begin
                            r_cnt <= {CW{1'b0}};
                        end
                    end
                    ST_CHECK_HI: begin
                        if (!r_sync) begin
                            r_cnt   <= {CW{1'b0}};
                            r_state <= ST_STABLE_LO;
                        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_cnt   <= {CW{1'b0}};
                            r_btn   <= 1'b1;
                            r_press <= 1'b1;
                            r_state <= ST_STABLE_HI;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_STABLE_HI: begin
                        if (!r_sync) begin
                            r_cnt   <= CW'(1);
                            r_state <= ST_CHECK_LO;
                        end else begin
                            r_cnt <= {CW{1'b0}};
                        end
                    end
                    ST_CHECK_LO: begin
                        if (r_sync) begin
                            r_cnt   <= {CW{1'b0}};
                            r_state <= ST_STABLE_HI;
                        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                            r_cnt     <= {CW{1'b0}};
                            r_btn     <= 1'b0;
                            r_release <= 1'b1;
                            r_state   <= ST_STABLE_LO;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    default: begin
                        r_cnt   <= {CW{1'b0}};
                        r_btn   <= 1'b0;
                        r_state <= ST_STABLE_LO;
                    end
                endcase
            end
        end

        assign w_btn[g]     = r_btn;
        assign w_press[g]   = r_press;
        assign w_release[g] = r_release;

`ifdef BTN_LONG_PRESS_EN
        localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES + 1) : 1;
        logic [HW-1:0] r_hold;
        logic          r_long;

        // Hold counter saturates at LONG_CYCLES so the pulse fires once per press.
        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                r_hold <= {HW{1'b0}};
                r_long <= 1'b0;
            end else if (!r_btn) begin
                r_hold <= {HW{1'b0}};
                r_long <= 1'b0;
            end else begin
                r_long <= (r_hold == HW'(LONG_CYCLES - 1));
                if (r_hold != HW'(LONG_CYCLES)) begin
                    r_hold <= r_hold + HW'(1);
                end else begin
                    r_hold <= r_hold;
                end
            end
        end

        assign w_long[g] = r_long;
`else
        assign w_long[g] = 1'b0;
`endif
    end

`ifndef BTN_LONG_PRESS_EN
    logic w_unused_long_cfg;
    assign w_unused_long_cfg = |LONG_CYCLES;
`endif

    assign bus.btn_o     = w_btn;
    assign bus.press_o   = w_press;
    assign bus.release_o = w_release;
    assign bus.long_o    = w_long;
endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random bouncing,
// all outputs compared every cycle against a behavioural reference model.
module tb_btn_debounce;
    localparam int N = 5;
    localparam int D = 8;
    localparam int L = 32;

    logic clk   = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_if #(.N_BTN(N)) bus ();

    btn_debounce #(
        .N_BTN(N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES(L)
    ) dut (
        .clk(clk),
        .arstn(arstn),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int tick_no = 0;

    // reference model: input history, clean level, run of disagreeing samples, hold length
    int m_s1[N], m_s2[N], m_lvl[N], m_run[N], m_hold[N];
    logic [N-1:0] e_btn = '0, e_press = '0, e_rel = '0, e_long = '0;

    int n_press[N], n_rel[N], n_long[N];
    int last_press[N], last_rel[N], last_long[N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at tick %0d: got %0h expected %0h", tag, tick_no, got, exp);
        end
    endtask

    task automatic model_step();
        logic [N-1:0] b;
        b = bus.btn_i;
        for (int i = 0; i < N; i++) begin
            if (!arstn) begin
                m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_hold[i] = 0;
                e_btn[i] = 1'b0; e_press[i] = 1'b0; e_rel[i] = 1'b0; e_long[i] = 1'b0;
            end else begin
                int sync_v;
                int lvl_pre;
                sync_v  = m_s2[i];
                lvl_pre = m_lvl[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = int'(b[i]);
                e_press[i] = 1'b0;
                e_rel[i]   = 1'b0;
                if (sync_v == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = sync_v;
                        m_run[i] = 0;
                        if (sync_v != 0) e_press[i] = 1'b1;
                        else             e_rel[i]   = 1'b1;
                    end
                end
                e_btn[i] = (m_lvl[i] != 0);
`ifdef BTN_LONG_PRESS_EN
                if (lvl_pre != 0) m_hold[i]++;
                else              m_hold[i] = 0;
                e_long[i] = (m_hold[i] == L);
`else
                e_long[i] = (lvl_pre < 0);
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick_no++;
        check_eq("btn_o",     32'(bus.btn_o),     32'(e_btn));
        check_eq("press_o",   32'(bus.press_o),   32'(e_press));
        check_eq("release_o", 32'(bus.release_o), 32'(e_rel));
        check_eq("long_o",    32'(bus.long_o),    32'(e_long));
        for (int i = 0; i < N; i++) begin
            if (bus.press_o[i])   begin n_press[i]++; last_press[i] = tick_no; end
            if (bus.release_o[i]) begin n_rel[i]++;   last_rel[i]   = tick_no; end
            if (bus.long_o[i])    begin n_long[i]++;  last_long[i]  = tick_no; end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int t0;
        int base;
        int base2;
        int rem[N];
        for (int i = 0; i < N; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
            last_press[i] = -1; last_rel[i] = -1; last_long[i] = -1;
            rem[i] = 0;
        end
        bus.btn_i = '0;
        run(3);
        arstn = 1'b1;
        run(3);

        // 1: clean press on channel 0
        bus.btn_i[0] = 1'b1;
        t0 = tick_no;
        run(12);
        check_eq("t1_latency", 32'(last_press[0] - t0), 32'd10);
        check_eq("t1_others", 32'(n_press[1] + n_press[2] + n_press[3] + n_press[4]), 32'd0);
        bus.btn_i[0] = 1'b0;
        run(12);

        // 2: short glitches on channel 1
        base = n_press[1];
        for (int r = 0; r < 4; r++) begin
            bus.btn_i[1] = 1'b1; run(5);
            bus.btn_i[1] = 1'b0; run(5);
        end
        check_eq("t2_no_press", 32'(n_press[1] - base), 32'd0);

        // 3: bounce then settle high on channel 2
        base = n_press[2];
        for (int t = 0; t < 10; t++) begin
            bus.btn_i[2] = ((t % 2) == 0);
            run(3);
        end
        bus.btn_i[2] = 1'b1;
        t0 = tick_no;
        run(14);
        check_eq("t3_count", 32'(n_press[2] - base), 32'd1);
        check_eq("t3_latency", 32'(last_press[2] - t0), 32'd10);
        bus.btn_i[2] = 1'b0;
        run(12);

        // 4: simultaneous press and release on channels 3 and 4
        base = n_rel[3];
        bus.btn_i[3] = 1'b1; bus.btn_i[4] = 1'b1;
        run(12);
        check_eq("t4_press_same", 32'(last_press[3]), 32'(last_press[4]));
        bus.btn_i[3] = 1'b0; bus.btn_i[4] = 1'b0;
        run(12);
        check_eq("t4_rel_same", 32'(last_rel[3]), 32'(last_rel[4]));
        check_eq("t4_rel_count", 32'(n_rel[3] - base), 32'd1);

        // 5: reset in the middle of a count
        bus.btn_i[0] = 1'b1;
        run(7);
        arstn = 1'b0;
        #1;
        check_eq("t5_rst_btn", 32'(bus.btn_o), 32'd0);
        check_eq("t5_rst_press", 32'(bus.press_o), 32'd0);
        run(3);
        arstn = 1'b1;
        t0 = tick_no;
        run(12);
        check_eq("t5_latency", 32'(last_press[0] - t0), 32'd10);
        bus.btn_i[0] = 1'b0;
        run(12);

        // 6: long hold, then a hold too short for a long pulse
        base = n_long[0];
        bus.btn_i[0] = 1'b1;
        run(60);
        bus.btn_i[0] = 1'b0;
        run(14);
`ifdef BTN_LONG_PRESS_EN
        check_eq("t6_long_count", 32'(n_long[0] - base), 32'd1);
        check_eq("t6_long_delay", 32'(last_long[0] - last_press[0]), 32'd32);
`else
        check_eq("t6_long_count", 32'(n_long[0] - base), 32'd0);
`endif
        base2 = n_long[0];
        bus.btn_i[0] = 1'b1;
        run(20);
        bus.btn_i[0] = 1'b0;
        run(14);
        check_eq("t6_short_hold", 32'(n_long[0] - base2), 32'd0);

        // random bouncing on every channel, with an occasional reset
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) begin
                    bus.btn_i[i] = 1'($urandom_range(0, 1));
                    rem[i] = (($urandom_range(0, 3) == 0) ? int'($urandom_range(D, 50))
                                                          : int'($urandom_range(1, 12)));
                end
                rem[i]--;
            end
            if ((c % 997) == 500) arstn = 1'b0;
            else                  arstn = 1'b1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
